fpnew_ordered_collector: RTL and testbench

Parametrised result collector that replaces the combinational round-robin output arbitration of the FPU top level. It sits between the per-opgroup operation blocks and the FPU result port. It records the issue order of operations across NumIn channels in a tracking FIFO of depth Depth, and returns results either in strict program order (InOrder=1) or in round-robin order (InOrder=0). Results pass through a registered output stage and issue is throttled by an outstanding-operation credit count.

---
 rtl/fpnew_ordered_collector.sv | 150 +++++++++++++++
 tb/tb_fpnew_ordered_collector.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_ordered_collector.sv
// Result collector for the FPU opgroup blocks: tracks outstanding operations and
// retires results either in issue order or round-robin through a registered output stage.
module fpnew_ordered_collector #(
  parameter int unsigned NumIn    = 5,
  parameter int unsigned Depth    = 8,
  parameter int unsigned Width    = 64,
  parameter int unsigned TagWidth = 1,
  parameter bit          InOrder  = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        issue_valid_i,
  input  logic [$clog2(NumIn)-1:0]    issue_chan_i,
  output logic                        issue_ready_o,
  input  logic [NumIn-1:0]            ch_valid_i,
  output logic [NumIn-1:0]            ch_ready_o,
  input  logic [NumIn*Width-1:0]      ch_result_i,
  input  logic [NumIn*5-1:0]          ch_status_i,
  input  logic [NumIn*TagWidth-1:0]   ch_tag_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [Width-1:0]            result_o,
  output logic [4:0]                  status_o,
  output logic [TagWidth-1:0]         tag_o,
  output logic                        busy_o,
  output logic [$clog2(Depth):0]      count_o
);

  localparam int unsigned ChanW = $clog2(NumIn);
  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [CntW-1:0]  DepthCnt = CntW'(Depth);
  localparam logic [ChanW-1:0] LastChan = ChanW'(NumIn - 1);

  // Issue-order FIFO of channel numbers; only written when retiring in order.
  logic [ChanW-1:0]    fifo_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic [ChanW-1:0]    rr_q;

  logic                out_valid_q;
  logic [Width-1:0]    result_q;
  logic [4:0]          status_q;
  logic [TagWidth-1:0] tag_q;

  logic [ChanW-1:0]    rr_sel;
  logic                rr_hit;
  logic [ChanW-1:0]    sel;
  logic                cand_valid;
  logic                stage_free;
  logic                accept;
  logic                issue_fire;

  // First valid channel at or above the rr pointer, wrapping at NumIn.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    rr_sel = rr_q;
    rr_hit = 1'b0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      idx = (32'(rr_q) + k) % NumIn;
      if (!rr_hit && ch_valid_i[idx]) begin
        rr_sel = idx[ChanW-1:0];
        rr_hit = 1'b1;
      end
    end
  end

  always_comb begin
    if (InOrder) begin
      sel        = fifo_q[rd_ptr_q];
      cand_valid = (count_q != '0) && ch_valid_i[sel];
    end else begin
      sel        = rr_sel;
      cand_valid = (count_q != '0) && rr_hit;
    end
  end

  assign stage_free    = ~out_valid_q | out_ready_i;
  assign accept        = cand_valid & stage_free & ~flush_i;
  assign issue_ready_o = (count_q != DepthCnt) & ~flush_i;
  assign issue_fire    = issue_valid_i & issue_ready_o;

  always_comb begin
    ch_ready_o = '0;
    if (accept) ch_ready_o[sel] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      status_q    <= '0;
      tag_q       <= '0;
    end else if (flush_i) begin
      // Flush clears everything except the fairness pointer.
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      status_q    <= '0;
      tag_q       <= '0;
    end else begin
      if (InOrder && issue_fire) begin
        fifo_q[wr_ptr_q] <= issue_chan_i;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end

      case ({issue_fire, accept})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (accept) begin
        result_q    <= ch_result_i[sel*Width +: Width];
        status_q    <= ch_status_i[sel*5 +: 5];
        tag_q       <= ch_tag_i[sel*TagWidth +: TagWidth];
        out_valid_q <= 1'b1;
        if (InOrder) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end else if (sel == LastChan) begin
          rr_q <= '0;
        end else begin
          rr_q <= sel + 1'b1;
        end
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign status_o    = status_q;
  assign tag_o       = tag_q;
  assign count_o     = count_q;
  assign busy_o      = (count_q != '0) | out_valid_q;

  // Dispatching to a nonexistent channel would corrupt the issue-order FIFO.
  a_legal_chan : assert property (@(posedge clk_i) disable iff (!rst_ni)
    issue_valid_i |-> (32'(issue_chan_i) < NumIn));

endmodule

// File: tb/tb_fpnew_ordered_collector.sv
// Directed bench for the ordered collector: one in-order and one round-robin
// instance share the stimulus; each scenario checks the instance it targets.
module tb_fpnew_ordered_collector;

  localparam int NI = 5;
  localparam int W  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, flush, issue_valid, out_ready;
  logic [2:0]      issue_chan;
  logic [NI-1:0]   ch_valid;
  logic [NI*W-1:0] ch_result;
  logic [NI*5-1:0] ch_status;
  logic [NI-1:0]   ch_tag;

  logic          o_issue_ready, o_out_valid, o_tag, o_busy;
  logic [NI-1:0] o_ch_ready;
  logic [W-1:0]  o_result;
  logic [4:0]    o_status;
  logic [3:0]    o_count;

  logic          r_issue_ready, r_out_valid, r_tag, r_busy;
  logic [NI-1:0] r_ch_ready;
  logic [W-1:0]  r_result;
  logic [4:0]    r_status;
  logic [3:0]    r_count;

  int n_cmp = 0;
  int n_bad = 0;

  fpnew_ordered_collector #(.NumIn(NI), .Depth(8), .Width(W), .TagWidth(1), .InOrder(1'b1)) u_ord (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_chan_i(issue_chan), .issue_ready_o(o_issue_ready),
    .ch_valid_i(ch_valid), .ch_ready_o(o_ch_ready), .ch_result_i(ch_result),
    .ch_status_i(ch_status), .ch_tag_i(ch_tag),
    .out_valid_o(o_out_valid), .out_ready_i(out_ready), .result_o(o_result),
    .status_o(o_status), .tag_o(o_tag), .busy_o(o_busy), .count_o(o_count)
  );

  fpnew_ordered_collector #(.NumIn(NI), .Depth(8), .Width(W), .TagWidth(1), .InOrder(1'b0)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_chan_i(issue_chan), .issue_ready_o(r_issue_ready),
    .ch_valid_i(ch_valid), .ch_ready_o(r_ch_ready), .ch_result_i(ch_result),
    .ch_status_i(ch_status), .ch_tag_i(ch_tag),
    .out_valid_o(r_out_valid), .out_ready_i(out_ready), .result_o(r_result),
    .status_o(r_status), .tag_o(r_tag), .busy_o(r_busy), .count_o(r_count)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [W-1:0] v);
    ch_result[c*W +: W] = v;
    ch_status[c*5 +: 5] = v[4:0];
    ch_tag[c]           = v[0];
  endtask

  task automatic do_reset;
    rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_chan = '0;
    ch_valid = '0; ch_result = '0; ch_status = '0; ch_tag = '0; out_ready = 1'b1;
    step;
    rst_n = 1'b1;
  endtask

  task automatic issue_n(input int n, input logic [2:0] c);
    issue_valid = 1'b1; issue_chan = c;
    for (int i = 0; i < n; i++) step;
    issue_valid = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %0b want 0", o_out_valid); end
    n_cmp++; if (o_result !== 64'h0) begin n_bad++; $display("FAIL rst_result got %0h want 0", o_result); end
    n_cmp++; if (o_count !== 4'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", o_count); end
    n_cmp++; if (o_issue_ready !== 1'b1) begin n_bad++; $display("FAIL rst_issue_ready got %0b want 1", o_issue_ready); end
    n_cmp++; if (o_ch_ready !== 5'b0) begin n_bad++; $display("FAIL rst_ch_ready got %b want 00000", o_ch_ready); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %0b want 0", o_busy); end
    n_cmp++; if (r_count !== 4'd0) begin n_bad++; $display("FAIL rst_rr_count got %0d want 0", r_count); end
  endtask

  task automatic test_order;
    do_reset;
    issue_valid = 1'b1;
    issue_chan = 3'd2; step;
    issue_chan = 3'd0; step;
    issue_chan = 3'd2; step;
    issue_valid = 1'b0;
    set_ch(0, 64'hAA); ch_valid = 5'b00001; #1;
    n_cmp++; if (o_ch_ready !== 5'b00000) begin n_bad++; $display("FAIL ord_hold_t3 got %b want 00000", o_ch_ready); end
    step;
    n_cmp++; if (o_ch_ready !== 5'b00000) begin n_bad++; $display("FAIL ord_hold_t4 got %b want 00000", o_ch_ready); end
    set_ch(2, 64'h11); ch_valid = 5'b00101; #1;
    n_cmp++; if (o_ch_ready !== 5'b00100) begin n_bad++; $display("FAIL ord_head_t5 got %b want 00100", o_ch_ready); end
    step;
    n_cmp++; if (o_result !== 64'h11 || o_out_valid !== 1'b1) begin n_bad++; $display("FAIL ord_first got %0h/%0b want 11/1", o_result, o_out_valid); end
    n_cmp++; if (o_status !== 5'h11 || o_tag !== 1'b1) begin n_bad++; $display("FAIL ord_first_flags got %0h/%0b want 11/1", o_status, o_tag); end
    set_ch(2, 64'h22); #1;
    n_cmp++; if (o_ch_ready !== 5'b00001) begin n_bad++; $display("FAIL ord_head_t6 got %b want 00001", o_ch_ready); end
    step;
    n_cmp++; if (o_result !== 64'hAA) begin n_bad++; $display("FAIL ord_second got %0h want aa", o_result); end
    ch_valid = 5'b00100; #1;
    n_cmp++; if (o_ch_ready !== 5'b00100) begin n_bad++; $display("FAIL ord_head_t7 got %b want 00100", o_ch_ready); end
    step;
    n_cmp++; if (o_result !== 64'h22 || o_count !== 4'd0) begin n_bad++; $display("FAIL ord_third got %0h/%0d want 22/0", o_result, o_count); end
    ch_valid = '0;
    step;
    n_cmp++; if (o_out_valid !== 1'b0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL ord_drain got %0b/%0b want 0/0", o_out_valid, o_busy); end
  endtask

  task automatic test_full;
    do_reset;
    issue_valid = 1'b1; issue_chan = 3'd1;
    for (int i = 0; i < 8; i++) step;
    n_cmp++; if (o_count !== 4'd8) begin n_bad++; $display("FAIL full_count got %0d want 8", o_count); end
    n_cmp++; if (o_issue_ready !== 1'b0) begin n_bad++; $display("FAIL full_issue_ready got %0b want 0", o_issue_ready); end
    set_ch(1, 64'h77); ch_valid = 5'b00010; #1;
    n_cmp++; if (o_ch_ready !== 5'b00010) begin n_bad++; $display("FAIL full_ch_ready got %b want 00010", o_ch_ready); end
    step;
    n_cmp++; if (o_count !== 4'd7) begin n_bad++; $display("FAIL full_after_pop got %0d want 7", o_count); end
    n_cmp++; if (o_issue_ready !== 1'b1) begin n_bad++; $display("FAIL full_reopen got %0b want 1", o_issue_ready); end
    n_cmp++; if (o_result !== 64'h77) begin n_bad++; $display("FAIL full_result got %0h want 77", o_result); end
    issue_valid = 1'b0; ch_valid = '0;
  endtask

  task automatic test_backpressure;
    do_reset;
    issue_n(3, 3'd3);
    out_ready = 1'b0;
    set_ch(3, 64'h100); ch_valid = 5'b01000; #1;
    n_cmp++; if (o_ch_ready !== 5'b01000) begin n_bad++; $display("FAIL bp_first_ready got %b want 01000", o_ch_ready); end
    step;
    set_ch(3, 64'h200);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (o_ch_ready !== 5'b0 || o_out_valid !== 1'b1 || o_result !== 64'h100) begin
        n_bad++; $display("FAIL bp_hold_%0d got %b/%0b/%0h want 00000/1/100", i, o_ch_ready, o_out_valid, o_result);
      end
      step;
    end
    n_cmp++; if (o_count !== 4'd2) begin n_bad++; $display("FAIL bp_count got %0d want 2", o_count); end
    out_ready = 1'b1; #1;
    n_cmp++; if (o_ch_ready !== 5'b01000) begin n_bad++; $display("FAIL bp_release got %b want 01000", o_ch_ready); end
    step;
    n_cmp++; if (o_result !== 64'h200) begin n_bad++; $display("FAIL bp_r2 got %0h want 200", o_result); end
    set_ch(3, 64'h300);
    step;
    n_cmp++; if (o_result !== 64'h300 || o_count !== 4'd0) begin n_bad++; $display("FAIL bp_r3 got %0h/%0d want 300/0", o_result, o_count); end
    #1;
    n_cmp++; if (o_ch_ready !== 5'b0) begin n_bad++; $display("FAIL bp_empty_block got %b want 00000", o_ch_ready); end
    ch_valid = '0;
    step;
  endtask

  task automatic test_round_robin;
    logic [4:0]  exp_mask [4];
    logic [63:0] exp_res  [4];
    exp_mask = '{5'b00010, 5'b01000, 5'b00010, 5'b01000};
    exp_res  = '{64'h1, 64'h3, 64'h1, 64'h3};
    do_reset;
    issue_n(4, 3'd1);
    set_ch(1, 64'h1); set_ch(3, 64'h3); ch_valid = 5'b01010;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (r_ch_ready !== exp_mask[i]) begin n_bad++; $display("FAIL rr_grant_%0d got %b want %b", i, r_ch_ready, exp_mask[i]); end
      step;
      n_cmp++; if (r_result !== exp_res[i]) begin n_bad++; $display("FAIL rr_result_%0d got %0h want %0h", i, r_result, exp_res[i]); end
    end
    #1;
    n_cmp++; if (r_count !== 4'd0 || r_ch_ready !== 5'b0) begin n_bad++; $display("FAIL rr_empty got %0d/%b want 0/00000", r_count, r_ch_ready); end
    ch_valid = '0;
  endtask

  task automatic test_flush;
    do_reset;
    issue_n(6, 3'd0);
    set_ch(0, 64'h55); ch_valid = 5'b00001;
    step;
    out_ready = 1'b0; flush = 1'b1; issue_valid = 1'b1; #1;
    n_cmp++; if (o_count !== 4'd5 || o_out_valid !== 1'b1) begin n_bad++; $display("FAIL fl_pre got %0d/%0b want 5/1", o_count, o_out_valid); end
    n_cmp++; if (o_issue_ready !== 1'b0) begin n_bad++; $display("FAIL fl_issue_ready got %0b want 0", o_issue_ready); end
    n_cmp++; if (o_ch_ready !== 5'b0) begin n_bad++; $display("FAIL fl_ch_ready got %b want 00000", o_ch_ready); end
    step;
    flush = 1'b0; issue_valid = 1'b0; ch_valid = '0; #1;
    n_cmp++; if (o_count !== 4'd0 || o_out_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_bad++; $display("FAIL fl_post got %0d/%0b/%0b want 0/0/0", o_count, o_out_valid, o_busy);
    end
    n_cmp++; if (o_result !== 64'h0) begin n_bad++; $display("FAIL fl_result got %0h want 0", o_result); end
    out_ready = 1'b1;
    issue_n(2, 3'd0);
    ch_valid = 5'b00011; #1;
    n_cmp++; if (r_ch_ready !== 5'b00010) begin n_bad++; $display("FAIL fl_rr_kept got %b want 00010", r_ch_ready); end
    ch_valid = '0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    issue_n(3, 3'd4);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    set_ch(4, 64'h99); ch_valid = 5'b10000; #1;
    n_cmp++; if (o_ch_ready !== 5'b0) begin n_bad++; $display("FAIL rm_ch_ready got %b want 00000", o_ch_ready); end
    n_cmp++; if (o_count !== 4'd0 || o_busy !== 1'b0 || o_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rm_state got %0d/%0b/%0b want 0/0/0", o_count, o_busy, o_out_valid);
    end
    n_cmp++; if (o_issue_ready !== 1'b1) begin n_bad++; $display("FAIL rm_issue_ready got %0b want 1", o_issue_ready); end
    step;
    n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_no_accept got %0b want 0", o_out_valid); end
    ch_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired after 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_order;
    test_full;
    test_backpressure;
    test_round_robin;
    test_flush;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
